id_ex_ctrl_stage: RTL and testbench
===================================

// Module: id_ex_ctrl_stage
// PURPOSE
//  Consumer side of the decode control bundle: the ID/EX pipeline register for all CU outputs,
//  plus register indices and PC. It detects load-use hazards, inserts bubbles and honours
//  flush and hold requests. It sits between the decode stage (CU, register file) and the
//  execute stage (ALU, branch unit).
// PARAMETERS
//  XLEN    32  width of the PC carried alongside the control bundle
//  REG_AW  5   register index width
//  CNT_W   16  width of the saturating stall/flush event counters
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       synchronous, active-high reset
//  id_valid      in   1       ID holds a real instruction
//  id_opcode     in   7       opcode of the ID instruction (for source-use decode)
//  id_pc         in   XLEN    PC of the ID instruction
//  id_rs1/id_rs2 in   REG_AW  source register indices
//  id_rd         in   REG_AW  destination register index
//  id_load, id_store, id_we, id_Type_alu, id_controlALU, id_controlOp1   in 1 each: CU outputs
//  id_Type_dm, id_salida_funct3, id_funct_imm   in 3 each: CU outputs
//  id_controlRF  in   2       CU output
//  id_BrOp       in   5       CU output
//  ex_flush      in   1       taken branch/jump resolved in EX this cycle
//  ex_hold       in   1       downstream busy: freeze the EX register
//  ex_*          out  (same)  registered copies of every id_* input above except id_opcode, id_rs1, id_rs2
//  ex_valid      out  1       EX holds a real instruction
//  stall_if_id   out  1       hold PC and IF/ID this cycle (combinational)
//  flush_if_id   out  1       squash IF/ID this cycle (= ex_flush)
//  stall_cnt     out  CNT_W   load-use stalls taken, saturating
//  flush_cnt     out  CNT_W   flushes taken, saturating
// BEHAVIOUR
//  - Reset: all ex_* outputs 0, ex_valid=0, both counters 0, FSM=RUN. A bubble is defined
//    as all control outputs 0: we=0, store=0, load=0, BrOp=5'b00000, valid=0.
//  - Use decode: rs1 is used unless opcode is lui (0110111), auipc (0010111) or jal (1101111).
//    rs2 is used only for R (0110011), S (0100011) and B (1100011).
//  - Hazard: ex_valid & ex_load & ex_rd!=0 & id_valid & ((use1 & id_rs1==ex_rd) | (use2 & id_rs2==ex_rd)).
//  - Per-cycle priority: rst > ex_flush > ex_hold > hazard > normal.
//    - ex_flush: EX <= bubble; flush_if_id=1; stall_if_id=0; flush_cnt++; FSM -> RUN.
//    - ex_hold (no flush): EX register unchanged; stall_if_id=1; no counters change.
//    - hazard: EX <= bubble; stall_if_id=1; stall_cnt++; FSM -> STALL.
//    - normal: EX <= ID bundle, with ex_valid=id_valid. If id_valid=0 the control fields are
//      forced to bubble values.
//  - FSM RUN/STALL: STALL lasts exactly one cycle. In STALL the load has moved on, so the
//    hazard cannot re-fire on the same pair. STALL -> RUN unconditionally, unless ex_hold
//    keeps it in STALL.
//  - Latency: one cycle from ID to EX. stall_if_id and flush_if_id are same-cycle combinational.
//  - Counters saturate at all-ones and never wrap.
//  - ex_flush together with a hazard: the flush wins, the stall is not counted, and the
//    ID instruction is discarded.
//  - rst asserted mid-stall or mid-hold: next state is the reset state, and the pending
//    instruction is dropped.
// STRUCTURE
//  - Shared package riscv_ctrl_pkg: opcode constants (OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI,
//    OP_AUIPC, OP_JAL, OP_JALR); BrOp codes (BR_NONE=00000, BR_BEQ=01000 .. BR_BGEU=01111,
//    BR_JUMP=11111); a packed ctrl_bundle_t typedef and its BUBBLE constant; FSM state enum.
//  - One sub-module, hazard_detect (combinational: use decode + compare), instantiated once.
// TESTING
//  1. lw x5 in EX, then add x6,x5,x7 in ID -> stall_if_id=1 for 1 cycle, EX bubble
//     (we=0, ex_valid=0), stall_cnt=1; add enters EX on the next cycle.
//  2. lw x0 in EX, then add x6,x0,x1 in ID -> no stall; stall_cnt stays 0.
//  3. lw x5 in EX, then lui x5 in ID (rs1 field=5) -> no stall (lui does not use rs1).
//  4. Hazard and ex_flush in the same cycle -> flush_if_id=1, stall_if_id=0, EX bubble,
//     flush_cnt=1, stall_cnt=0.
//  5. ex_hold=1 for 3 cycles with a valid beq (BrOp=01000) in EX -> EX fields unchanged
//     and stall_if_id=1 throughout; the next ID bundle is captured on the first cycle
//     after the hold drops.
//  6. Force 2^CNT_W+5 hazards -> stall_cnt=16'hFFFF (saturated); then rst -> counters 0,
//     all ex_* outputs 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared decode/execute control definitions.
// Opcodes, branch codes, the ID/EX control bundle and stage FSM states.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_BEQ  = 5'b01000;
  localparam logic [4:0] BR_BNE  = 5'b01001;
  localparam logic [4:0] BR_BLT  = 5'b01100;
  localparam logic [4:0] BR_BGE  = 5'b01101;
  localparam logic [4:0] BR_BLTU = 5'b01110;
  localparam logic [4:0] BR_BGEU = 5'b01111;
  localparam logic [4:0] BR_JUMP = 5'b11111;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       we;
    logic       type_alu;
    logic       control_alu;
    logic       control_op1;
    logic [2:0] type_dm;
    logic [2:0] funct3;
    logic [2:0] funct_imm;
    logic [1:0] control_rf;
    logic [4:0] br_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    logic u;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: u = 1'b0;
      default:                  u = 1'b1;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    logic u;
    case (op)
      OP_R, OP_S, OP_B: u = 1'b1;
      default:          u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_hazard.sv
// Load-use hazard detector: source-use decode of the ID
// instruction compared against a load destination in EX.
module hazard_detect
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              hazard_o
);

  logic use1;
  logic use2;
  logic hit1;
  logic hit2;
  logic ld_live;

  assign use1 = uses_rs1(id_opcode_i);
  assign use2 = uses_rs2(id_opcode_i);

  // x0 never carries a produced value, so it never stalls.
  assign ld_live = ex_valid_i & ex_load_i
                 & (ex_rd_i != '0);

  assign hit1 = use1 & (id_rs1_i == ex_rd_i);
  assign hit2 = use2 & (id_rs2_i == ex_rd_i);

  assign hazard_o = ld_live & id_valid_i
                  & (hit1 | hit2);

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for decode control, with load-use
// stall, flush and hold handling plus saturating event counters.
module id_ex_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_load,
  input  logic              id_store,
  input  logic              id_we,
  input  logic              id_Type_alu,
  input  logic              id_controlALU,
  input  logic              id_controlOp1,
  input  logic [2:0]        id_Type_dm,
  input  logic [2:0]        id_salida_funct3,
  input  logic [2:0]        id_funct_imm,
  input  logic [1:0]        id_controlRF,
  input  logic [4:0]        id_BrOp,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_load,
  output logic              ex_store,
  output logic              ex_we,
  output logic              ex_Type_alu,
  output logic              ex_controlALU,
  output logic              ex_controlOp1,
  output logic [2:0]        ex_Type_dm,
  output logic [2:0]        ex_salida_funct3,
  output logic [2:0]        ex_funct_imm,
  output logic [1:0]        ex_controlRF,
  output logic [4:0]        ex_BrOp,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_bundle_t      id_ctrl;
  ctrl_bundle_t      ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  state_e            state_q, state_d;
  logic              hz_raw;
  logic              hazard;

  assign id_ctrl = '{
    load:        id_load,
    store:       id_store,
    we:          id_we,
    type_alu:    id_Type_alu,
    control_alu: id_controlALU,
    control_op1: id_controlOp1,
    type_dm:     id_Type_dm,
    funct3:      id_salida_funct3,
    funct_imm:   id_funct_imm,
    control_rf:  id_controlRF,
    br_op:       id_BrOp
  };

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid_i  (valid_q),
    .ex_load_i   (ctrl_q.load),
    .ex_rd_i     (rd_q),
    .id_valid_i  (id_valid),
    .id_opcode_i (id_opcode),
    .id_rs1_i    (id_rs1),
    .id_rs2_i    (id_rs2),
    .hazard_o    (hz_raw)
  );

  // In STALL the EX slot already holds the bubble, so the
  // same load/consumer pair cannot trigger a second stall.
  assign hazard = hz_raw & (state_q == ST_RUN);

  assign flush_if_id = ex_flush;
  assign stall_if_id = ~ex_flush & (ex_hold | hazard);

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    scnt_d  = scnt_q;
    fcnt_d  = fcnt_q;
    state_d = state_q;
    if (ex_flush) begin
      ctrl_d  = BUBBLE;
      valid_d = 1'b0;
      pc_d    = '0;
      rd_d    = '0;
      state_d = ST_RUN;
      if (fcnt_q != '1)
        fcnt_d = fcnt_q + CNT_W'(1);
    end else if (ex_hold) begin
      state_d = state_q;
    end else if (hazard) begin
      ctrl_d  = BUBBLE;
      valid_d = 1'b0;
      pc_d    = '0;
      rd_d    = '0;
      state_d = ST_STALL;
      if (scnt_q != '1)
        scnt_d = scnt_q + CNT_W'(1);
    end else begin
      ctrl_d  = id_valid ? id_ctrl : BUBBLE;
      valid_d = id_valid;
      pc_d    = id_pc;
      rd_d    = id_rd;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd_q    <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
      state_q <= ST_RUN;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_pc            = pc_q;
  assign ex_rd            = rd_q;
  assign ex_load          = ctrl_q.load;
  assign ex_store         = ctrl_q.store;
  assign ex_we            = ctrl_q.we;
  assign ex_Type_alu      = ctrl_q.type_alu;
  assign ex_controlALU    = ctrl_q.control_alu;
  assign ex_controlOp1    = ctrl_q.control_op1;
  assign ex_Type_dm       = ctrl_q.type_dm;
  assign ex_salida_funct3 = ctrl_q.funct3;
  assign ex_funct_imm     = ctrl_q.funct_imm;
  assign ex_controlRF     = ctrl_q.control_rf;
  assign ex_BrOp          = ctrl_q.br_op;
  assign stall_cnt        = scnt_q;
  assign flush_cnt        = fcnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage; a narrow-counter
// instance shares the stimulus to reach saturation quickly.
module tb_id_ex_ctrl_stage;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] S   = 7'b0100011;
  localparam logic [6:0] B   = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;

  logic clk = 0, rst = 1;
  logic id_valid = 0;
  logic [6:0] id_opcode = 0;
  logic [31:0] id_pc = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic id_load = 0, id_store = 0, id_we = 0;
  logic id_Type_alu = 0, id_controlALU = 0, id_controlOp1 = 0;
  logic [2:0] id_Type_dm = 0, id_salida_funct3 = 0;
  logic [2:0] id_funct_imm = 0;
  logic [1:0] id_controlRF = 0;
  logic [4:0] id_BrOp = 0;
  logic ex_flush = 0, ex_hold = 0;

  logic ex_valid, ex_load, ex_store, ex_we;
  logic ex_Type_alu, ex_controlALU, ex_controlOp1;
  logic [31:0] ex_pc;
  logic [4:0] ex_rd, ex_BrOp;
  logic [2:0] ex_Type_dm, ex_salida_funct3, ex_funct_imm;
  logic [1:0] ex_controlRF;
  logic stall_if_id, flush_if_id;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_valid, s_load, s_store, s_we;
  logic s_Type_alu, s_controlALU, s_controlOp1;
  logic [31:0] s_pc;
  logic [4:0] s_rd, s_BrOp;
  logic [2:0] s_Type_dm, s_funct3, s_funct_imm;
  logic [1:0] s_controlRF;
  logic s_stall, s_flush;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  id_ex_ctrl_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_load(id_load), .id_store(id_store), .id_we(id_we),
    .id_Type_alu(id_Type_alu), .id_controlALU(id_controlALU),
    .id_controlOp1(id_controlOp1), .id_Type_dm(id_Type_dm),
    .id_salida_funct3(id_salida_funct3),
    .id_funct_imm(id_funct_imm), .id_controlRF(id_controlRF),
    .id_BrOp(id_BrOp), .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_load(ex_load), .ex_store(ex_store), .ex_we(ex_we),
    .ex_Type_alu(ex_Type_alu), .ex_controlALU(ex_controlALU),
    .ex_controlOp1(ex_controlOp1), .ex_Type_dm(ex_Type_dm),
    .ex_salida_funct3(ex_salida_funct3),
    .ex_funct_imm(ex_funct_imm), .ex_controlRF(ex_controlRF),
    .ex_BrOp(ex_BrOp), .stall_if_id(stall_if_id),
    .flush_if_id(flush_if_id), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  id_ex_ctrl_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_load(id_load), .id_store(id_store), .id_we(id_we),
    .id_Type_alu(id_Type_alu), .id_controlALU(id_controlALU),
    .id_controlOp1(id_controlOp1), .id_Type_dm(id_Type_dm),
    .id_salida_funct3(id_salida_funct3),
    .id_funct_imm(id_funct_imm), .id_controlRF(id_controlRF),
    .id_BrOp(id_BrOp), .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rd(s_rd),
    .ex_load(s_load), .ex_store(s_store), .ex_we(s_we),
    .ex_Type_alu(s_Type_alu), .ex_controlALU(s_controlALU),
    .ex_controlOp1(s_controlOp1), .ex_Type_dm(s_Type_dm),
    .ex_salida_funct3(s_funct3),
    .ex_funct_imm(s_funct_imm), .ex_controlRF(s_controlRF),
    .ex_BrOp(s_BrOp), .stall_if_id(s_stall),
    .flush_if_id(s_flush), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, ld, st, we, ta, ca, c1;
    logic [4:0] br, rd;
    logic [2:0] tdm, f3, fi;
    logic [1:0] crf;
    logic [31:0] pc;
    int sc, fc;
  } exp_t;

  exp_t m;
  exp_t q[$];
  exp_t e;
  int nchk = 0, nfail = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic model_hz();
    logic u1, u2;
    u1 = !(id_opcode inside {LUI, AUI, JAL});
    u2 = id_opcode inside {R, S, B};
    return m.v && m.ld && m.rd != 0 && id_valid &&
      ((u1 && id_rs1 == m.rd) || (u2 && id_rs2 == m.rd));
  endfunction

  function automatic logic exp_stall();
    return !ex_flush && (ex_hold || model_hz());
  endfunction

  task automatic set_id(input logic v, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] pc);
    id_valid = v; id_opcode = op; id_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_pc = pc;
    id_load = (op == LD);
    id_store = (op == S);
    id_we = op inside {R, I, LD, LUI, AUI, JAL, JLR};
    id_Type_alu = (op == R);
    id_controlALU = op inside {R, I};
    id_controlOp1 = (op == AUI);
    id_Type_dm = (op == LD || op == S) ? 3'b010 : 3'b000;
    id_salida_funct3 = pc[4:2];
    id_funct_imm = op[4:2];
    id_controlRF = (op == LD) ? 2'b01 : 2'b10;
    id_BrOp = (op == B) ? 5'b01000 :
              (op == JAL || op == JLR) ? 5'b11111 : 5'b00000;
  endtask

  // Advance one clock: update the reference model from the
  // currently driven inputs and queue the expected EX state.
  task automatic tick();
    logic hz;
    hz = model_hz();
    if (rst) begin
      m = '{default: '0};
    end else if (ex_flush) begin
      m.v = 0; m.ld = 0; m.st = 0; m.we = 0; m.ta = 0;
      m.ca = 0; m.c1 = 0; m.br = 0; m.rd = 0; m.tdm = 0;
      m.f3 = 0; m.fi = 0; m.crf = 0; m.pc = 0;
      m.fc++;
    end else if (ex_hold) begin
      m.sc = m.sc;
    end else if (hz) begin
      m.v = 0; m.ld = 0; m.st = 0; m.we = 0; m.ta = 0;
      m.ca = 0; m.c1 = 0; m.br = 0; m.rd = 0; m.tdm = 0;
      m.f3 = 0; m.fi = 0; m.crf = 0; m.pc = 0;
      m.sc++;
    end else begin
      m.v = id_valid; m.rd = id_rd; m.pc = id_pc;
      m.ld = id_valid & id_load;
      m.st = id_valid & id_store;
      m.we = id_valid & id_we;
      m.ta = id_valid & id_Type_alu;
      m.ca = id_valid & id_controlALU;
      m.c1 = id_valid & id_controlOp1;
      m.br = id_valid ? id_BrOp : 5'b0;
      m.tdm = id_valid ? id_Type_dm : 3'b0;
      m.f3 = id_valid ? id_salida_funct3 : 3'b0;
      m.fi = id_valid ? id_funct_imm : 3'b0;
      m.crf = id_valid ? id_controlRF : 2'b0;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; set_id(1, R, 3, 1, 2, 32'h100);
    tick();
    e = q.pop_front();
    nchk++;
    if ({ex_valid, ex_load, ex_store, ex_we, ex_BrOp, ex_rd,
         ex_pc, ex_Type_dm, ex_controlRF} !== '0) begin
      nfail++;
      $display("FAIL reset_ex: got v=%b we=%b br=%b rd=%0d pc=%h req all 0",
               ex_valid, ex_we, ex_BrOp, ex_rd, ex_pc);
    end
    nchk++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || s_stall_cnt !== 0) begin
      nfail++;
      $display("FAIL reset_cnt: got s=%0d f=%0d req 0 0",
               stall_cnt, flush_cnt);
    end
    rst = 0;
  endtask

  task automatic test_load_use();
    set_id(1, LD, 5, 1, 0, 32'h200);
    #1; tick(); e = q.pop_front();
    set_id(1, R, 6, 5, 7, 32'h204);
    #1;
    nchk++;
    if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
      nfail++;
      $display("FAIL lu_stall: got st=%b fl=%b req st=1 fl=0",
               stall_if_id, flush_if_id);
    end
    tick(); e = q.pop_front();
    nchk++;
    if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_load !== 1'b0 ||
        ex_BrOp !== 5'b0 || stall_cnt !== 16'd1) begin
      nfail++;
      $display("FAIL lu_bubble: got v=%b we=%b cnt=%0d req v=0 we=0 cnt=1",
               ex_valid, ex_we, stall_cnt);
    end
    #1;
    nchk++;
    if (stall_if_id !== 1'b0) begin
      nfail++;
      $display("FAIL lu_release: got st=%b req 0", stall_if_id);
    end
    tick(); e = q.pop_front();
    nchk++;
    if (ex_valid !== e.v || ex_we !== e.we || ex_rd !== 5'd6 ||
        ex_pc !== 32'h204 || ex_Type_alu !== e.ta) begin
      nfail++;
      $display("FAIL lu_add_in_ex: got v=%b rd=%0d pc=%h req v=1 rd=6 pc=204",
               ex_valid, ex_rd, ex_pc);
    end
  endtask

  // Pairs a load in EX with a consumer candidate in ID.
  task automatic test_no_stall_cases();
    logic [6:0] ops [4] = '{R, LUI, I, S};
    logic [4:0] lrd [4] = '{0, 5, 5, 5};
    logic [4:0] r1s [4] = '{0, 5, 1, 1};
    logic [4:0] r2s [4] = '{1, 0, 5, 5};
    logic       st  [4] = '{0, 0, 0, 1};
    for (int k = 0; k < 4; k++) begin
      set_id(1, LD, lrd[k], 2, 0, 32'h300 + k * 16);
      #1; tick(); e = q.pop_front();
      set_id(1, ops[k], 6, r1s[k], r2s[k], 32'h304 + k * 16);
      #1;
      nchk++;
      if (stall_if_id !== st[k] || stall_if_id !== exp_stall()) begin
        nfail++;
        $display("FAIL use_decode%0d: got st=%b req %b", k,
                 stall_if_id, st[k]);
      end
      tick(); e = q.pop_front();
      nchk++;
      if (ex_valid !== e.v || ex_rd !== e.rd ||
          stall_cnt !== 16'(sat(e.sc, 65535))) begin
        nfail++;
        $display("FAIL use_ex%0d: got v=%b rd=%0d cnt=%0d req v=%b rd=%0d cnt=%0d",
                 k, ex_valid, ex_rd, stall_cnt, e.v, e.rd, e.sc);
      end
      set_id(0, I, 0, 0, 0, 0);
      #1; tick(); e = q.pop_front();
    end
  endtask

  task automatic test_flush_hazard();
    int sc0;
    sc0 = m.sc;
    set_id(1, LD, 5, 1, 0, 32'h400);
    #1; tick(); e = q.pop_front();
    set_id(1, R, 6, 5, 7, 32'h404);
    ex_flush = 1;
    #1;
    nchk++;
    if (flush_if_id !== 1'b1 || stall_if_id !== 1'b0) begin
      nfail++;
      $display("FAIL fh_comb: got fl=%b st=%b req fl=1 st=0",
               flush_if_id, stall_if_id);
    end
    tick(); e = q.pop_front();
    ex_flush = 0;
    nchk++;
    if (ex_valid !== 1'b0 || ex_we !== 1'b0 || flush_cnt !== 16'd1 ||
        stall_cnt !== 16'(sc0)) begin
      nfail++;
      $display("FAIL fh_ex: got v=%b we=%b f=%0d s=%0d req v=0 we=0 f=1 s=%0d",
               ex_valid, ex_we, flush_cnt, stall_cnt, sc0);
    end
  endtask

  task automatic test_hold();
    set_id(1, B, 0, 1, 2, 32'h500);
    #1; tick(); e = q.pop_front();
    set_id(1, R, 9, 3, 4, 32'h504);
    ex_hold = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      nchk++;
      if (stall_if_id !== 1'b1) begin
        nfail++;
        $display("FAIL hold_stall%0d: got %b req 1", k, stall_if_id);
      end
      tick(); e = q.pop_front();
      nchk++;
      if (ex_BrOp !== 5'b01000 || ex_valid !== 1'b1 ||
          ex_pc !== 32'h500 || ex_BrOp !== e.br) begin
        nfail++;
        $display("FAIL hold_ex%0d: got br=%b v=%b pc=%h req br=01000 v=1 pc=500",
                 k, ex_BrOp, ex_valid, ex_pc);
      end
    end
    ex_hold = 0;
    #1; tick(); e = q.pop_front();
    nchk++;
    if (ex_rd !== 5'd9 || ex_pc !== 32'h504 || ex_BrOp !== 5'b0 ||
        ex_valid !== 1'b1) begin
      nfail++;
      $display("FAIL hold_release: got rd=%0d pc=%h br=%b req rd=9 pc=504 br=0",
               ex_rd, ex_pc, ex_BrOp);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [9] = '{R, I, LD, S, B, LUI, AUI, JAL, JLR};
    for (int k = 0; k < 80; k++) begin
      set_id(1'($urandom_range(0, 5) != 0),
             ops[$urandom_range(0, 8)],
             5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
             5'($urandom_range(0, 4)), 32'h1000 + k * 4);
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      #1;
      nchk++;
      if (stall_if_id !== exp_stall() || flush_if_id !== ex_flush) begin
        nfail++;
        $display("FAIL b2b_comb%0d: got st=%b fl=%b req st=%b fl=%b", k,
                 stall_if_id, flush_if_id, exp_stall(), ex_flush);
      end
      tick(); e = q.pop_front();
      nchk++;
      if ({ex_valid, ex_load, ex_store, ex_we, ex_Type_alu,
           ex_controlALU, ex_controlOp1, ex_BrOp, ex_rd,
           ex_Type_dm, ex_salida_funct3, ex_funct_imm,
           ex_controlRF, ex_pc} !==
          {e.v, e.ld, e.st, e.we, e.ta, e.ca, e.c1, e.br, e.rd,
           e.tdm, e.f3, e.fi, e.crf, e.pc} ||
          stall_cnt !== 16'(e.sc) || flush_cnt !== 16'(e.fc)) begin
        nfail++;
        $display("FAIL b2b_ex%0d: got v=%b we=%b br=%b rd=%0d pc=%h s=%0d f=%0d req v=%b we=%b br=%b rd=%0d pc=%h s=%0d f=%0d",
                 k, ex_valid, ex_we, ex_BrOp, ex_rd, ex_pc,
                 stall_cnt, flush_cnt, e.v, e.we, e.br, e.rd,
                 e.pc, e.sc, e.fc);
      end
    end
    ex_flush = 0; ex_hold = 0;
  endtask

  task automatic test_saturate();
    rst = 1; #1; tick(); e = q.pop_front(); rst = 0;
    set_id(1, LD, 5, 5, 0, 32'h600);
    for (int k = 0; k < 42; k++) begin
      #1; tick(); e = q.pop_front();
      nchk++;
      if (s_stall_cnt !== 4'(sat(e.sc, 15)) ||
          stall_cnt !== 16'(e.sc)) begin
        nfail++;
        $display("FAIL sat_step%0d: got s4=%0d s16=%0d req s4=%0d s16=%0d",
                 k, s_stall_cnt, stall_cnt, sat(e.sc, 15), e.sc);
      end
    end
    nchk++;
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd21) begin
      nfail++;
      $display("FAIL sat_final: got s4=%h s16=%0d req s4=f s16=21",
               s_stall_cnt, stall_cnt);
    end
    ex_hold = 1; rst = 1;
    #1; tick(); e = q.pop_front();
    rst = 0; ex_hold = 0;
    nchk++;
    if ({ex_valid, ex_load, ex_we, ex_BrOp, ex_rd, ex_pc,
         stall_cnt, flush_cnt, s_stall_cnt} !== '0) begin
      nfail++;
      $display("FAIL sat_reset: got v=%b ld=%b rd=%0d s=%0d s4=%0d req all 0",
               ex_valid, ex_load, ex_rd, stall_cnt, s_stall_cnt);
    end
  endtask

  task automatic test_rst_mid_stall();
    set_id(1, LD, 7, 1, 0, 32'h700);
    #1; tick(); e = q.pop_front();
    set_id(1, S, 0, 2, 7, 32'h704);
    #1; tick(); e = q.pop_front();
    rst = 1;
    #1; tick(); e = q.pop_front();
    rst = 0;
    nchk++;
    if ({ex_valid, ex_store, ex_pc, stall_cnt} !== '0) begin
      nfail++;
      $display("FAIL rst_stall: got v=%b st=%b pc=%h s=%0d req all 0",
               ex_valid, ex_store, ex_pc, stall_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '{default: '0};
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_flush_hazard();
    test_hold();
    test_back_to_back();
    test_saturate();
    test_rst_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
